// File: rtl/hdc_chunk_trainer.sv
// HDC class trainer: per-class saturating counters + thresholded binary HV, CHUNK_W dims/cycle; `HDC_THRESH_PROG_EN adds a programmable threshold.
// Latency: accept at edge t writes chunks at t+1..t+N_CHUNK, done pulses after; readout registered, 1 cycle, read-old.
// Backpressure: in_ready only in IDLE (clr low) or on the last chunk, so back-to-back HVs stream with no bubble.
module hdc_chunk_trainer #(
  parameter int HV_W    = 50,
  parameter int CHUNK_W = 5,
  parameter int CNT_W   = 8,
  parameter int N_CLASS = 26,
  parameter int THRESH  = 1,
  localparam int N_CHUNK = HV_W / CHUNK_W,
  localparam int CLASS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
  localparam int SLICE_W = CHUNK_W * CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic [HV_W-1:0]    in_hv,
  input  logic               clr,
  output logic               busy,
  output logic [IDX_W-1:0]   chunk_idx,
  output logic               done,
  output logic               class_err,
`ifdef HDC_THRESH_PROG_EN
  input  logic               thresh_wr,
  input  logic [CNT_W-1:0]   thresh_in,
`endif
  input  logic [CLASS_W-1:0] rd_class,
  input  logic [IDX_W-1:0]   rd_chunk,
  output logic [CHUNK_W-1:0] rd_bin,
  output logic [SLICE_W-1:0] rd_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_CHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state;
  logic [HV_W-1:0]         hv_q;
  logic [CLASS_W-1:0]      class_q;
  logic [HV_W*CNT_W-1:0]   cnt [N_CLASS];
  logic [HV_W-1:0]         bin [N_CLASS];
  logic [CNT_W-1:0]        thr;

  logic                    last, accept, class_ok, wr_en, rd_ok;
  logic [SLICE_W-1:0]      old_slice, new_slice;
  logic [CHUNK_W-1:0]      hv_slice, new_bin;

  assign last     = (state == ACCUM) && (chunk_idx == LAST);
  assign in_ready = ((state == IDLE) && !clr) || last;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ACCUM);
  assign class_ok = int'(class_q) < N_CLASS;
  assign wr_en    = (state == ACCUM) && class_ok;

  // Post-add counter and its thresholded bit for the chunk being walked.
  always_comb begin
    old_slice = '0;
    new_slice = '0;
    new_bin   = '0;
    hv_slice  = hv_q[int'(chunk_idx)*CHUNK_W +: CHUNK_W];
    if (class_ok) old_slice = cnt[class_q][int'(chunk_idx)*SLICE_W +: SLICE_W];
    for (int j = 0; j < CHUNK_W; j++) begin
      new_slice[j*CNT_W +: CNT_W] = old_slice[j*CNT_W +: CNT_W]
        + CNT_W'(hv_slice[j] && (old_slice[j*CNT_W +: CNT_W] != CNT_MAX));
      new_bin[j] = new_slice[j*CNT_W +: CNT_W] >= thr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chunk_idx <= '0;
      done      <= 1'b0;
      class_err <= 1'b0;
      hv_q      <= '0;
      class_q   <= '0;
      for (int c = 0; c < N_CLASS; c++) begin
        cnt[c] <= '0;
        bin[c] <= '0;
      end
    end else begin
      done <= last;
      if (wr_en) begin
        cnt[class_q][int'(chunk_idx)*SLICE_W +: SLICE_W] <= new_slice;
        bin[class_q][int'(chunk_idx)*CHUNK_W +: CHUNK_W] <= new_bin;
      end
      if (accept) begin
        state     <= ACCUM;
        chunk_idx <= '0;
        hv_q      <= in_hv;
        class_q   <= in_class;
        if (int'(in_class) >= N_CLASS) class_err <= 1'b1;
      end else if (last) begin
        state     <= IDLE;
        chunk_idx <= '0;
      end else if (state == ACCUM) begin
        chunk_idx <= chunk_idx + 1'b1;
      end else if (clr) begin
        for (int c = 0; c < N_CLASS; c++) begin
          cnt[c] <= '0;
          bin[c] <= '0;
        end
      end
    end
  end

`ifdef HDC_THRESH_PROG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           thr <= CNT_W'(THRESH);
    else if (thresh_wr && state == IDLE) thr <= thresh_in;
  end
`else
  assign thr = CNT_W'(THRESH);
`endif

  assign rd_ok = (int'(rd_class) < N_CLASS) && (int'(rd_chunk) < N_CHUNK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin <= '0;
      rd_cnt <= '0;
    end else if (rd_ok) begin
      rd_bin <= bin[rd_class][int'(rd_chunk)*CHUNK_W +: CHUNK_W];
      rd_cnt <= cnt[rd_class][int'(rd_chunk)*SLICE_W +: SLICE_W];
    end else begin
      rd_bin <= '0;
      rd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hdc_chunk_trainer.sv
// Bench for hdc_chunk_trainer: directed + random stimulus against a per-dimension counter model.
module tb_hdc_chunk_trainer;

  localparam int HV_W = 50, CHUNK_W = 5, CNT_W = 8, N_CLASS = 26, THRESH = 1;
  localparam int N_CHUNK = 10, CLASS_W = 5, IDX_W = 4, SLICE_W = 40, CNT_MAX = 255;

  logic               clk, rst, in_valid, in_ready, clr, busy, done, class_err;
  logic [CLASS_W-1:0] in_class, rd_class;
  logic [HV_W-1:0]    in_hv;
  logic [IDX_W-1:0]   chunk_idx, rd_chunk;
  logic [CHUNK_W-1:0] rd_bin;
  logic [SLICE_W-1:0] rd_cnt;
`ifdef HDC_THRESH_PROG_EN
  logic               thresh_wr;
  logic [CNT_W-1:0]   thresh_in;
`endif

  hdc_chunk_trainer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_hv(in_hv), .clr(clr), .busy(busy),
    .chunk_idx(chunk_idx), .done(done), .class_err(class_err),
`ifdef HDC_THRESH_PROG_EN
    .thresh_wr(thresh_wr), .thresh_in(thresh_in),
`endif
    .rd_class(rd_class), .rd_chunk(rd_chunk), .rd_bin(rd_bin), .rd_cnt(rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: plain per-class, per-dimension counts.
  int               mcnt [N_CLASS][HV_W];
  bit               mbin [N_CLASS][HV_W];
  logic [HV_W-1:0]  m_hv;
  int               m_cls, m_rem, m_thr;
  bit               m_done, m_err, m_acc;
  logic [CHUNK_W-1:0] m_rd_bin;
  logic [SLICE_W-1:0] m_rd_cnt;
  bit               s_done, s_ready;
  int               done_cnt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mcnt[c, d]) begin
      mcnt[c][d] = 0;
      mbin[c][d] = 0;
    end
    m_hv = '0; m_cls = 0; m_rem = 0; m_thr = THRESH;
    m_done = 0; m_err = 0; m_acc = 0; m_rd_bin = '0; m_rd_cnt = '0;
  endtask

  function automatic bit exp_ready();
    return ((m_rem == 0) && !clr) || (m_rem == 1);
  endfunction

  task automatic check();
    chk("in_ready", in_ready, exp_ready());
    chk("busy", busy, m_rem > 0);
    chk("chunk_idx", chunk_idx, (m_rem > 0) ? N_CHUNK - m_rem : 0);
    chk("done", done, m_done);
    chk("class_err", class_err, m_err);
    chk("rd_bin", rd_bin, m_rd_bin);
    chk("rd_cnt", rd_cnt, m_rd_cnt);
  endtask

  // Everything the next rising edge does, from the inputs now on the pins.
  task automatic model_edge();
    bit idle, rdy;
    int k, d;
    idle = (m_rem == 0);
    rdy  = exp_ready();
    m_rd_bin = '0;
    m_rd_cnt = '0;
    if (int'(rd_class) < N_CLASS && int'(rd_chunk) < N_CHUNK)
      for (int j = 0; j < CHUNK_W; j++) begin
        d = int'(rd_chunk) * CHUNK_W + j;
        m_rd_bin[j] = mbin[rd_class][d];
        m_rd_cnt[j*CNT_W +: CNT_W] = CNT_W'(mcnt[rd_class][d]);
      end
    m_done = 0;
    if (m_rem > 0) begin
      k = N_CHUNK - m_rem;
      if (m_cls < N_CLASS)
        for (int j = 0; j < CHUNK_W; j++) begin
          d = k * CHUNK_W + j;
          if (m_hv[d] && mcnt[m_cls][d] < CNT_MAX) mcnt[m_cls][d]++;
          mbin[m_cls][d] = (mcnt[m_cls][d] >= m_thr);
        end
      m_done = (m_rem == 1);
      m_rem--;
    end
    m_acc = in_valid && rdy;
    if (m_acc) begin
      m_hv = in_hv; m_cls = int'(in_class); m_rem = N_CHUNK;
      if (m_cls >= N_CLASS) m_err = 1;
    end else if (idle && clr) begin
      foreach (mcnt[c, dd]) begin
        mcnt[c][dd] = 0;
        mbin[c][dd] = 0;
      end
    end
`ifdef HDC_THRESH_PROG_EN
    if (idle && thresh_wr) m_thr = int'(thresh_in);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    s_done  = done;
    s_ready = in_ready;
    check();
    if (s_done) done_cnt++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_rem != 0 || m_done) && guard < N_CHUNK + 4) begin
      cycle();
      guard++;
    end
  endtask

  task automatic train(int c, logic [HV_W-1:0] hv, int n);
    int acc_n, guard;
    acc_n = 0; guard = 0;
    in_valid = 1; in_class = CLASS_W'(c); in_hv = hv; clr = 0;
    while (acc_n < n && guard < n * N_CHUNK + 20) begin
      cycle();
      if (m_acc) acc_n++;
      guard++;
    end
    in_valid = 0;
    chk("train_accepts", acc_n, n);
    drain();
  endtask

  task automatic rd_lit(string nm, int c, int k, logic [CHUNK_W-1:0] eb, logic [SLICE_W-1:0] ec);
    in_valid = 0; clr = 0;
    rd_class = CLASS_W'(c); rd_chunk = IDX_W'(k);
    cycle();
    chk({nm, "_bin"}, rd_bin, eb);
    chk({nm, "_cnt"}, rd_cnt, ec);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HV_W-1:0] ones;
    logic [63:0]     r;
    int n, d0, guard;
    ones = '1;
    rst = 1; in_valid = 0; in_class = '0; in_hv = '0; clr = 0;
    rd_class = '0; rd_chunk = '0;
`ifdef HDC_THRESH_PROG_EN
    thresh_wr = 0; thresh_in = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", chunk_idx, 0);
    chk("rst_err", class_err, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    rst = 0;

    // All-ones HV to class 3: latency and readback.
    rd_class = 3; rd_chunk = 0;
    in_valid = 1; in_class = 3; in_hv = ones;
    cycle();
    in_valid = 0; n = 0;
    s_done = 0;
    while (!s_done && n < 50) begin
      cycle();
      n++;
    end
    chk("t1_done_latency", n, 11);
    for (int k = 0; k < N_CHUNK; k++) rd_lit("t1", 3, k, 5'h1f, 40'h0101010101);
    rd_lit("t1_class2", 2, 0, 5'h00, 40'h0);
    rd_lit("rd_oor_chunk", 3, 12, 5'h00, 40'h0);
    rd_lit("rd_oor_class", 30, 0, 5'h00, 40'h0);

    // clr in IDLE blocks acceptance and wipes storage.
    in_valid = 1; in_class = 5; in_hv = ones; clr = 1;
    cycle();
    chk("clr_in_ready", s_ready, 0);
    chk("clr_no_accept", busy, 0);
    clr = 0; in_valid = 0;
    rd_lit("clr_wiped", 3, 0, 5'h00, 40'h0);

    // Back-to-back: four HVs with only dimension 0 set.
    d0 = done_cnt;
    train(0, 50'd1, 4);
    chk("b2b_done_pulses", done_cnt - d0, 4);
    rd_lit("b2b_c0", 0, 0, 5'b00001, 40'h04);
    rd_lit("b2b_c1", 0, 1, 5'h00, 40'h0);

    // Out-of-range class: full sequence, no write, sticky error.
    d0 = done_cnt;
    r = {$urandom(), $urandom()};
    train(30, r[HV_W-1:0], 1);
    chk("oor_done", done_cnt - d0, 1);
    chk("oor_err", class_err, 1);
    train(2, ones, 1);
    chk("oor_err_sticky", class_err, 1);

    // Saturation: 260 all-ones HVs against 8-bit counters.
    train(1, ones, 260);
    rd_lit("sat_c0", 1, 0, 5'h1f, 40'hff_ffff_ffff);
    rd_lit("sat_c9", 1, 9, 5'h1f, 40'hff_ffff_ffff);

    // Asynchronous reset mid-HV, then clean retraining.
    rd_class = 1; rd_chunk = 0;
    in_valid = 1; in_class = 4; in_hv = ones;
    cycle();
    in_valid = 0; guard = 0;
    while (chunk_idx != 4 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("rst_mid_idx", chunk_idx, 4);
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_idx0", chunk_idx, 0);
    chk("rst_mid_err", class_err, 0);
    chk("rst_mid_rd_cnt", rd_cnt, 0);
    chk("rst_mid_rd_bin", rd_bin, 0);
    rst = 0;
    model_reset();
    train(4, ones, 1);
    rd_lit("retrain_c0", 4, 0, 5'h1f, 40'h0101010101);
    rd_lit("retrain_c9", 4, 9, 5'h1f, 40'h0101010101);
    rd_lit("retrain_sat_gone", 1, 0, 5'h00, 40'h0);

    // Random traffic, including out-of-range classes/reads and clr.
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom()};
      in_hv    = r[HV_W-1:0];
      in_valid = ($urandom_range(0, 1) == 1);
      in_class = CLASS_W'($urandom_range(0, 31));
      clr      = ($urandom_range(0, 7) == 0);
      rd_class = CLASS_W'($urandom_range(0, 31));
      rd_chunk = IDX_W'($urandom_range(0, 15));
      cycle();
    end
    in_valid = 0; clr = 0;
    drain();

`ifdef HDC_THRESH_PROG_EN
    clr = 1;
    cycle();
    clr = 0; thresh_wr = 1; thresh_in = 8'd2;
    cycle();
    thresh_wr = 0;
    train(7, ones, 1);
    rd_lit("thr_first", 7, 0, 5'h00, 40'h0101010101);
    train(7, ones, 1);
    rd_lit("thr_second", 7, 0, 5'h1f, 40'h0202020202);
    clr = 1;
    cycle();
    clr = 0;
    rd_lit("thr_clr", 7, 0, 5'h00, 40'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
